// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed driver for a 4-digit common-anode 7-segment display,
//           fed from four BCD digits with frame-aligned double buffering.
// Latency : every output is registered; it reflects the scan/display state one cycle earlier.
// Backpressure: none. load_i is a fire-and-forget strobe; the latest load before a frame
//           boundary wins, and one that coincides with the boundary is shown in the next frame.
//
// Ports
//   clk_i          only clock
//   rst_i          synchronous, active-high reset (overrides load_i)
//   c0_i..c3_i     BCD digits, c0_i least significant
//   load_i         one-cycle strobe sampling c0_i..c3_i and dp_mask_i
//   dp_mask_i      decimal-point enables, bit i belongs to digit i
//   an_o           anode enables, active low, an_o[i] drives digit i
//   seg_o          segments {g,f,e,d,c,b,a}, active low
//   dp_o           decimal point, active low
//   frame_done_o   one-cycle pulse in the cycle after each frame boundary

module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV   = 50000, // clocks per digit slot, >= GUARD+2
    parameter int unsigned GUARD         = 16,    // all-off clocks at the start of each slot
    parameter bit          BLANK_LEADING = 1'b1   // suppress leading zeros on digits 3..1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] c0_i,
    input  logic [3:0] c1_i,
    input  logic [3:0] c2_i,
    input  logic [3:0] c3_i,
    input  logic       load_i,
    input  logic [3:0] dp_mask_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       frame_done_o
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    localparam logic [6:0] SEG_OFF  = 7'b111_1111;
    localparam logic [6:0] SEG_DASH = 7'b011_1111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [1:0]    idx_q,      idx_d;
    logic [15:0]   pend_dig_q, pend_dig_d;
    logic [3:0]    pend_dp_q,  pend_dp_d;
    logic          pend_v_q,   pend_v_d;
    logic [15:0]   disp_dig_q, disp_dig_d;
    logic [3:0]    disp_dp_q,  disp_dp_d;

    logic [3:0]    an_q,       an_d;
    logic [6:0]    seg_q,      seg_d;
    logic          dp_q,       dp_d;
    logic          fdone_q,    fdone_d;

    // ------------------------------------------------------------------
    // Prescaler and scan index
    // ------------------------------------------------------------------
    logic slot_end;
    logic frame_end;
    logic in_guard;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);
    // GUARD == 0 turns the guard interval off entirely.
    assign in_guard  = (GUARD != 0) && (cnt_q < GUARD_C);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pending / display double buffer
    // ------------------------------------------------------------------
    logic [15:0] in_dig;
    assign in_dig = {c3_i, c2_i, c1_i, c0_i};

    always_comb begin
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_v_d   = pend_v_q;
        disp_dig_d = disp_dig_q;
        disp_dp_d  = disp_dp_q;

        if (load_i) begin
            pend_dig_d = in_dig;
            pend_dp_d  = dp_mask_i;
        end

        if (frame_end) begin
            // A load on the boundary itself bypasses the pending stage so it
            // is visible in the very next frame; pending is then stale.
            pend_v_d = 1'b0;
            if (load_i) begin
                disp_dig_d = in_dig;
                disp_dp_d  = dp_mask_i;
            end else if (pend_v_q) begin
                disp_dig_d = pend_dig_q;
                disp_dp_d  = pend_dp_q;
            end
        end else if (load_i) begin
            pend_v_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection, leading-zero detection and decode
    // ------------------------------------------------------------------
    logic [3:0] cur_dig;
    logic       cur_dp_en;
    logic [3:0] dig_zero;
    logic [3:0] lead_zero;
    logic       cur_blank;
    logic [6:0] cur_seg;

    always_comb begin
        cur_dig   = disp_dig_q[3:0];
        cur_dp_en = disp_dp_q[0];
        case (idx_q)
            2'd0: begin cur_dig = disp_dig_q[3:0];   cur_dp_en = disp_dp_q[0]; end
            2'd1: begin cur_dig = disp_dig_q[7:4];   cur_dp_en = disp_dp_q[1]; end
            2'd2: begin cur_dig = disp_dig_q[11:8];  cur_dp_en = disp_dp_q[2]; end
            default: begin cur_dig = disp_dig_q[15:12]; cur_dp_en = disp_dp_q[3]; end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dig_zero[i] = (disp_dig_q[4*i +: 4] == 4'd0);
        end
    end

    // lead_zero[k]: digit k and every more significant digit are zero.
    // Digit 0 always shows, so a display of all zeros reads "0".
    always_comb begin
        lead_zero[3] = dig_zero[3];
        lead_zero[2] = dig_zero[3] & dig_zero[2];
        lead_zero[1] = dig_zero[3] & dig_zero[2] & dig_zero[1];
        lead_zero[0] = 1'b0;
    end

    assign cur_blank = BLANK_LEADING && lead_zero[idx_q];

    always_comb begin
        cur_seg = SEG_DASH;
        case (cur_dig)
            4'd0: cur_seg = 7'b100_0000;
            4'd1: cur_seg = 7'b111_1001;
            4'd2: cur_seg = 7'b010_0100;
            4'd3: cur_seg = 7'b011_0000;
            4'd4: cur_seg = 7'b001_1001;
            4'd5: cur_seg = 7'b001_0010;
            4'd6: cur_seg = 7'b000_0010;
            4'd7: cur_seg = 7'b111_1000;
            4'd8: cur_seg = 7'b000_0000;
            4'd9: cur_seg = 7'b001_0000;
            default: cur_seg = SEG_DASH; // non-BCD codes show a dash
        endcase
    end

    // ------------------------------------------------------------------
    // Output next-state
    // ------------------------------------------------------------------
    // Anodes come from a single registered index, so at most one is ever
    // low; the guard at each slot start keeps the old digit's segments from
    // ghosting onto the new anode.
    always_comb begin
        an_d    = 4'b1111;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        fdone_d = frame_end;
        if (!in_guard) begin
            an_d = ~(4'b0001 << idx_q);
            if (!cur_blank) begin
                seg_d = cur_seg;
                dp_d  = ~cur_dp_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            pend_dig_q <= 16'h0000;
            pend_dp_q  <= 4'h0;
            pend_v_q   <= 1'b0;
            disp_dig_q <= 16'h0000;
            disp_dp_q  <= 4'h0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            fdone_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fdone_q    <= fdone_d;
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = fdone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver with a small scan, a cycle-time
//           reference model and directed literal checks followed by random loads/resets.
// Latency : model predicts the registered outputs produced by each clock edge.
// Backpressure: n/a.

module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int GD = 2;
    localparam int FRAME = 4 * RD;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] c0_i = 4'd0, c1_i = 4'd0, c2_i = 4'd0, c3_i = 4'd0;
    logic       load_i = 1'b0;
    logic [3:0] dp_mask_i = 4'd0;
    logic [3:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;
    logic       frame_done_o;

    seg7_scan_driver #(
        .REFRESH_DIV  (RD),
        .GUARD        (GD),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .c0_i        (c0_i),
        .c1_i        (c1_i),
        .c2_i        (c2_i),
        .c3_i        (c3_i),
        .load_i      (load_i),
        .dp_mask_i   (dp_mask_i),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: time since reset decides slot and phase; the
    // display/pending contents are plain arrays.
    // ------------------------------------------------------------------
    logic [6:0] segtab [16];
    initial begin
        segtab[0]  = 7'b1000000; segtab[1]  = 7'b1111001;
        segtab[2]  = 7'b0100100; segtab[3]  = 7'b0110000;
        segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000;
        segtab[8]  = 7'b0000000; segtab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) segtab[i] = 7'b0111111;
    end

    int         t = 0;
    bit         started = 0;
    logic [3:0] md [4];
    logic [3:0] mdp;
    logic [3:0] mp [4];
    logic [3:0] mpdp;
    bit         mpv;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;

    always @(posedge clk_i) begin
        int  pos, slot;
        bit  blank;
        logic [3:0] ins [4];
        cyc++;
        started = 1;
        ins[0] = c0_i; ins[1] = c1_i; ins[2] = c2_i; ins[3] = c3_i;
        if (rst_i) begin
            t = 0;
            for (int j = 0; j < 4; j++) begin md[j] = 0; mp[j] = 0; end
            mdp = 0; mpdp = 0; mpv = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            pos  = t % RD;
            slot = (t / RD) % 4;
            if (pos < GD) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = 4'hF ^ (4'b0001 << slot);
                blank = (slot > 0);
                for (int j = slot; j < 4; j++) if (md[j] != 0) blank = 0;
                exp_seg = blank ? 7'h7F : segtab[md[slot]];
                exp_dp  = blank ? 1'b1 : ~mdp[slot];
            end
            exp_fd = ((t % FRAME) == FRAME - 1);
            if ((t % FRAME) == FRAME - 1) begin
                if (load_i) begin
                    for (int j = 0; j < 4; j++) md[j] = ins[j];
                    mdp = dp_mask_i;
                end else if (mpv) begin
                    for (int j = 0; j < 4; j++) md[j] = mp[j];
                    mdp = mpdp;
                end
                mpv = 0;
            end else if (load_i) begin
                for (int j = 0; j < 4; j++) mp[j] = ins[j];
                mpdp = dp_mask_i;
                mpv = 1;
            end
            t++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        if (started) begin
            checks++;
            if ({an_o, seg_o, dp_o, frame_done_o} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL model cyc=%0d: got an=%b seg=%b dp=%b fd=%b expected an=%b seg=%b dp=%b fd=%b",
                         cyc, an_o, seg_o, dp_o, frame_done_o, exp_an, exp_seg, exp_dp, exp_fd);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (all return at a negedge)
    // ------------------------------------------------------------------
    task automatic wait_an(input logic [3:0] target, input string nm);
        int n = 0;
        @(negedge clk_i);
        while (an_o !== target && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) check({nm, "_timeout"}, {28'd0, an_o}, {28'd0, target});
    endtask

    task automatic expect_digit(input logic [3:0] target, input logic [6:0] seg_e,
                                input logic dp_e, input string nm);
        wait_an(target, nm);
        check({nm, "_seg"}, {25'd0, seg_o}, {25'd0, seg_e});
        check({nm, "_dp"},  {31'd0, dp_o},  {31'd0, dp_e});
    endtask

    task automatic pulse_load(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic [3:0] dpm);
        c3_i = d3; c2_i = d2; c1_i = d1; c0_i = d0; dp_mask_i = dpm;
        load_i = 1'b1;
        @(negedge clk_i);
        load_i = 1'b0;
    endtask

    // After reset release: two guard cycles, then six cycles of digit 0 showing "0".
    task automatic check_restart(input string nm);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        for (int k = 0; k < RD; k++) begin
            @(negedge clk_i);
            an_e  = (k < GD) ? 4'b1111 : 4'b1110;
            seg_e = (k < GD) ? 7'b1111111 : 7'b1000000;
            check($sformatf("%s_an%0d", nm, k), {28'd0, an_o}, {28'd0, an_e});
            check($sformatf("%s_seg%0d", nm, k), {25'd0, seg_o}, {25'd0, seg_e});
        end
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "_an"},  {28'd0, an_o},  32'hF);
        check({nm, "_seg"}, {25'd0, seg_o}, 32'h7F);
        check({nm, "_dp"},  {31'd0, dp_o},  32'h1);
        check({nm, "_fd"},  {31'd0, frame_done_o}, 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int fd_t [5];
        int n;

        // Reset and first slot
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_outs("reset");
        rst_i = 1'b0;
        check_restart("first");
        expect_digit(4'b1101, 7'b1111111, 1'b1, "blank_d1");
        expect_digit(4'b0111, 7'b1111111, 1'b1, "blank_d3");

        // Double buffering: load during digit-1 slot
        wait_an(4'b1101, "db_wait");
        pulse_load(4'd4, 4'd3, 4'd2, 4'd1, 4'b0001);
        expect_digit(4'b1011, 7'b1111111, 1'b1, "db_cur_d2");
        expect_digit(4'b1110, 7'b1111001, 1'b0, "db_d0");
        expect_digit(4'b1101, 7'b0100100, 1'b1, "db_d1");
        expect_digit(4'b1011, 7'b0110000, 1'b1, "db_d2");
        expect_digit(4'b0111, 7'b0011001, 1'b1, "db_d3");

        // Blanking and invalid code
        pulse_load(4'd0, 4'd0, 4'd5, 4'hA, 4'b0000);
        expect_digit(4'b1110, 7'b0111111, 1'b1, "inv_d0");
        expect_digit(4'b1101, 7'b0010010, 1'b1, "inv_d1");
        expect_digit(4'b1011, 7'b1111111, 1'b1, "inv_d2");
        expect_digit(4'b0111, 7'b1111111, 1'b1, "inv_d3");

        // Load exactly at the frame boundary (cnt=7, idx=3)
        wait_an(4'b1110, "fb_wait0");
        wait_an(4'b0111, "fb_wait3");
        repeat (4) @(posedge clk_i);
        #1;
        c3_i = 4'd8; c2_i = 4'd0; c1_i = 4'd6; c0_i = 4'd7; dp_mask_i = 4'b0100;
        load_i = 1'b1;
        @(posedge clk_i);
        #1 load_i = 1'b0;
        @(negedge clk_i);
        check("fb_frame_done", {31'd0, frame_done_o}, 32'h1);
        expect_digit(4'b1110, 7'b1111000, 1'b1, "fb_d0");
        expect_digit(4'b1011, 7'b1000000, 1'b0, "fb_d2");

        // Load overwrite within one frame
        wait_an(4'b1101, "ow_wait1");
        pulse_load(4'd1, 4'd1, 4'd1, 4'd1, 4'b1111);
        wait_an(4'b1011, "ow_wait2");
        pulse_load(4'd9, 4'd8, 4'd7, 4'd6, 4'b0000);
        expect_digit(4'b1110, 7'b0000010, 1'b1, "ow_d0");
        expect_digit(4'b1101, 7'b1111000, 1'b1, "ow_d1");
        expect_digit(4'b1011, 7'b0000000, 1'b1, "ow_d2");
        expect_digit(4'b0111, 7'b0010000, 1'b1, "ow_d3");

        // frame_done period over four frames
        for (int k = 0; k < 5; k++) begin
            n = 0;
            @(negedge clk_i);
            while (frame_done_o !== 1'b1 && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 100) check("fd_timeout", {31'd0, frame_done_o}, 32'h1);
            fd_t[k] = cyc;
        end
        for (int k = 1; k < 5; k++)
            check($sformatf("fd_period%0d", k), fd_t[k] - fd_t[k-1], FRAME);

        // Mid-operation reset during the digit-2 slot
        wait_an(4'b1011, "mr_wait");
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_reset_outs("midrst");
        check_restart("midrst");

        // Randomised loads and occasional resets, checked by the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_i);
            rst_i  = ($urandom_range(0, 399) == 0);
            load_i = ($urandom_range(0, 9) == 0);
            c0_i = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            c1_i = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            c2_i = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            c3_i = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            dp_mask_i = 4'($urandom);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        load_i = 1'b0;
        repeat (2 * FRAME) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Drives a 4-digit, common-anode, time-multiplexed 7-segment display from four BCD digits (c3 = most significant … c0 = least significant), such as those produced by the decimal up-counter. It scans one digit per refresh slot and inserts an all-off guard interval at each digit change to suppress ghosting. New digit values are double-buffered and applied only at frame boundaries, so a frame is never torn. It sits between the counter and the board pins.

## Interface
- REFRESH_DIV, 50000: clocks per digit slot. Must satisfy REFRESH_DIV ≥ GUARD+2.
- GUARD, 16: clocks at the start of each slot with all anodes off. 0 disables the guard interval.
- BLANK_LEADING, 1: 1 enables leading-zero blanking.
- clk  input  1  system clock. This is the block's only clock.
- rst  input  1  synchronous, active-high reset.
- c0, c1, c2, c3  input  4 each  BCD digits. c0 is the least significant.
- load  input  1  single-cycle strobe. Samples c0–c3 and dp_mask into the pending buffer.
- dp_mask  input  4  decimal point enable, one bit per digit. Bit i is digit i.
- an  output  4  anode enables, active low. an[i] enables digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- frame_done  output  1  one-cycle pulse after each frame boundary.

## Operation
- **Prescaler and scan index**
  - cnt counts 0..REFRESH_DIV-1 and then wraps to 0. Its width is clog2(REFRESH_DIV).
  - idx (2 bits) increments mod 4 on each cnt wrap.
  - Scan order is digit 0, 1, 2, 3, 0, …
- **Buffers**
  - Pending: pend_d[15:0], pend_dp[3:0], pend_v.
  - Display: disp_d, disp_dp.
  - load=1: pending takes the inputs and pend_v is set. A later load overwrites the pending values (latest wins).
- **Frame boundary** is the cycle with cnt==REFRESH_DIV-1 and idx==3. At that edge:
  - If load=1 in the same cycle, the inputs go directly to the display buffer and pend_v clears.
  - Otherwise, if pend_v=1, pending copies to display and pend_v clears.
  - Otherwise the display buffer holds.
- **Decode** of disp digit[idx]:
  - 0–9 use the standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10–15 display a dash: 0111111 (segment g only).
- **Leading-zero blanking** (BLANK_LEADING=1):
  - Digit k (k=3,2,1) is blanked when digit k and every higher digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit has seg=1111111 and dp=1. Its anode is still driven normally.
- **dp** = ~disp_dp[idx] for a non-blanked digit.
- **Reset** (rst=1 at an edge): cnt=0, idx=0, all buffers 0, pend_v=0. Outputs take an=1111, seg=1111111, dp=1, frame_done=0. rst overrides load.

## Timing
- All outputs are registered and reflect the pre-edge cnt/idx/disp state (1-cycle latency).
  - an <= (cnt < GUARD) ? 1111 : ~(1<<idx).
  - seg/dp <= decode of digit idx. During guard cycles, seg=1111111 and dp=1.
- frame_done is high for exactly the one cycle following the frame-boundary edge. Period: 4·REFRESH_DIV clocks.
- Timeline from the first edge with rst=0: GUARD cycles of an=1111, then digit 0 for REFRESH_DIV-GUARD cycles, then the guard for digit 1, and so on.
- Load-to-display latency:
  - At most one full frame plus 1 cycle.
  - Exactly 1 cycle when load coincides with the frame boundary.
- rst asserted mid-slot: outputs show reset values in the next cycle. The scan restarts at digit 0 with the guard interval, and pending data is discarded.
- Only one anode is ever low at a time. No two anodes are low in the same cycle, including across a slot change.

## Test plan
All scenarios use REFRESH_DIV=8, GUARD=2, BLANK_LEADING=1.

- **Reset and first slot.** Hold rst for 3 cycles, then release.
  - While in reset: an=1111, seg=1111111, dp=1, frame_done=0.
  - After release: 2 cycles of an=1111, then 6 cycles of an=1110, seg=1000000 ("0").
  - Digits 1–3: an active, seg=1111111 (blanked).
- **Double buffering.** In the digit-1 slot, pulse load with c3..c0=4,3,2,1 and dp_mask=0001.
  - The current frame is unchanged.
  - Next frame: digit 0 seg=1111001 with dp=0, digit 1 0100100, digit 2 0110000, digit 3 0011001.
- **Blanking and invalid code.** Load c3..c0=0,0,5,A.
  - Digits 3 and 2 show 1111111.
  - Digit 1 shows 0010010.
  - Digit 0 shows 0111111.
- **Load at the frame boundary.** Pulse load exactly at cnt=7, idx=3.
  - New values appear in the very next digit-0 active window.
  - frame_done pulses 1 cycle after that edge.
- **Load overwrite.** Pulse load twice in one frame, with values 1111 and then 9876.
  - Only 9876 is displayed next frame.
  - frame_done period is exactly 32 cycles over 4 frames.
- **Mid-operation reset.** Assert rst for 1 cycle during the digit-2 slot.
  - The next cycle shows reset outputs.
  - The scan restarts at the digit-0 guard, and the display shows "0".
